// File: rtl/seq_controller.sv
// VeriRISC sequencing controller: integrated 8-phase sequencer, memory wait-state stalls,
// resumable HALTED state and illegal-opcode trapping. Strobes decode from registered state.
module seq_controller #(
  parameter int unsigned OPC_WIDTH = 3,
  parameter bit          WAIT_EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OPC_WIDTH-1:0] opcode,
  input  logic                 zero,
  input  logic                 mem_ready,
  input  logic                 run,
  output logic [2:0]           phase,
  output logic                 sel,
  output logic                 rd,
  output logic                 ld_ir,
  output logic                 inc_pc,
  output logic                 halt,
  output logic                 ld_pc,
  output logic                 data_e,
  output logic                 ld_ac,
  output logic                 wr,
  output logic                 halted,
  output logic                 illegal
);

  typedef enum logic [0:0] {
    StRun,
    StHalted
  } state_e;

  typedef enum logic [2:0] {
    OpHlt,
    OpSkz,
    OpAdd,
    OpAnd,
    OpXor,
    OpLda,
    OpSto,
    OpJmp
  } opc_e;

  state_e     state_q, state_d;
  logic [2:0] phase_q, phase_d;
  logic       illegal_q, illegal_d;

  opc_e base_op;
  logic illegal_op;
  logic is_alu;
  logic is_hlt;
  logic is_skz;
  logic is_sto;
  logic is_jmp;
  logic stall;

  assign base_op = opc_e'(opcode[2:0]);

  // Any set bit above the base 3-bit field marks the opcode as illegal.
  if (OPC_WIDTH > 3) begin : g_wide_opc
    assign illegal_op = |opcode[OPC_WIDTH-1:3];
  end else begin : g_base_opc
    assign illegal_op = 1'b0;
  end

  assign is_alu = !illegal_op && (base_op inside {OpAdd, OpAnd, OpXor, OpLda});
  assign is_hlt = illegal_op || (base_op == OpHlt);
  assign is_skz = !illegal_op && (base_op == OpSkz);
  assign is_sto = !illegal_op && (base_op == OpSto);
  assign is_jmp = !illegal_op && (base_op == OpJmp);

  // Strobe decode
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    if (state_q == StRun) begin
      unique case (phase_q)
        3'd0: begin
          sel = 1'b1;
        end
        3'd1: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        3'd2, 3'd3: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        3'd4: begin
          inc_pc = 1'b1;
          halt   = is_hlt;
        end
        3'd5: begin
          rd = is_alu;
        end
        3'd6: begin
          rd     = is_alu;
          inc_pc = is_skz && zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        3'd7: begin
          rd     = is_alu;
          ld_ac  = is_alu;
          data_e = is_sto;
          wr     = is_sto;
          ld_pc  = is_jmp;
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

  // A read in progress holds the whole controller until memory answers.
  assign stall = WAIT_EN && rd && !mem_ready;

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    illegal_d = illegal_q;
    unique case (state_q)
      StRun: begin
        if (!stall) begin
          if (halt) begin
            state_d   = StHalted;
            phase_d   = 3'd0;
            illegal_d = illegal_op;
          end else begin
            phase_d = phase_q + 3'd1;
          end
        end
      end
      StHalted: begin
        if (run) begin
          state_d   = StRun;
          phase_d   = 3'd0;
          illegal_d = 1'b0;
        end
      end
      default: begin
        state_d = StRun;
        phase_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StRun;
      phase_q   <= 3'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      illegal_q <= illegal_d;
    end
  end

  assign phase   = phase_q;
  assign halted  = (state_q == StHalted);
  assign illegal = illegal_q;

endmodule

// File: tb/tb_seq_controller.sv
// Scoreboard bench for seq_controller: a 4-bit-opcode waiting instance and a 3-bit no-wait
// instance, checked phase by phase against a decode table.
module tb_seq_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a;
  logic       rst_b;
  logic [3:0] opcode_a;
  logic [2:0] opcode_b;
  logic       zero;
  logic       run;
  logic       mem_ready_a;
  logic       mem_ready_b;

  logic [2:0] phase_a, phase_b;
  logic sel_a, rd_a, ld_ir_a, inc_pc_a, halt_a, ld_pc_a, data_e_a, ld_ac_a, wr_a;
  logic halted_a, illegal_a;
  logic sel_b, rd_b, ld_ir_b, inc_pc_b, halt_b, ld_pc_b, data_e_b, ld_ac_b, wr_b;
  logic halted_b, illegal_b;

  seq_controller #(.OPC_WIDTH(4), .WAIT_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst_a), .opcode(opcode_a), .zero(zero), .mem_ready(mem_ready_a),
    .run(run), .phase(phase_a), .sel(sel_a), .rd(rd_a), .ld_ir(ld_ir_a), .inc_pc(inc_pc_a),
    .halt(halt_a), .ld_pc(ld_pc_a), .data_e(data_e_a), .ld_ac(ld_ac_a), .wr(wr_a),
    .halted(halted_a), .illegal(illegal_a)
  );

  seq_controller #(.OPC_WIDTH(3), .WAIT_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .opcode(opcode_b), .zero(zero), .mem_ready(mem_ready_b),
    .run(run), .phase(phase_b), .sel(sel_b), .rd(rd_b), .ld_ir(ld_ir_b), .inc_pc(inc_pc_b),
    .halt(halt_b), .ld_pc(ld_pc_b), .data_e(data_e_b), .ld_ac(ld_ac_b), .wr(wr_b),
    .halted(halted_b), .illegal(illegal_b)
  );

  logic [13:0] obs_a, obs_b;
  assign obs_a = {phase_a, sel_a, rd_a, ld_ir_a, inc_pc_a, halt_a, ld_pc_a, data_e_a, ld_ac_a,
                  wr_a, halted_a, illegal_a};
  assign obs_b = {phase_b, sel_b, rd_b, ld_ir_b, inc_pc_b, halt_b, ld_pc_b, data_e_b, ld_ac_b,
                  wr_b, halted_b, illegal_b};

  typedef struct {
    string       name;
    logic [13:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Expected {phase, strobes, halted, illegal} from the opcode decode table.
  function automatic logic [13:0] expect_vec(input logic [2:0] ph, input logic hl,
                                             input logic il, input logic [3:0] opc,
                                             input logic z);
    logic s, r, li, ip, h, lp, de, la, w;
    logic alu, bad;
    {s, r, li, ip, h, lp, de, la, w} = 9'b0;
    bad = (opc > 4'd7);
    alu = (opc >= 4'd2) && (opc <= 4'd5);
    if (!hl) begin
      case (ph)
        3'd0: s = 1'b1;
        3'd1: begin s = 1'b1; r = 1'b1; end
        3'd2, 3'd3: begin s = 1'b1; r = 1'b1; li = 1'b1; end
        3'd4: begin ip = 1'b1; h = bad || (opc == 4'd0); end
        3'd5: r = alu;
        3'd6: begin
          r  = alu;
          ip = (opc == 4'd1) && z;
          lp = (opc == 4'd7);
          de = (opc == 4'd6);
        end
        default: begin
          r  = alu;
          la = alu;
          de = (opc == 4'd6);
          w  = (opc == 4'd6);
          lp = (opc == 4'd7);
        end
      endcase
    end
    return {ph, s, r, li, ip, h, lp, de, la, w, hl, il};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input string nm, input logic [2:0] ph, input logic hl, input logic il);
    exp_t e;
    e.name = nm;
    e.v    = expect_vec(ph, hl, il, opcode_a, zero);
    sb.push_back(e);
  endtask

  task automatic push_b(input string nm, input logic [2:0] ph, input logic hl, input logic il);
    exp_t e;
    e.name = nm;
    e.v    = expect_vec(ph, hl, il, {1'b0, opcode_b}, zero);
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    #1;
    push_a("reset_state", 3'd0, 1'b0, 1'b0);
    #1;
    e = sb.pop_front();
    n_checks++;
    if (obs_a !== e.v) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", e.name, obs_a, e.v);
    end
    tick();
    rst_a = 1'b1;
  endtask

  task automatic test_decode_add();
    exp_t e;
    opcode_a    = 4'd2;
    zero        = 1'b0;
    mem_ready_a = 1'b1;
    for (int i = 0; i < 14; i++) begin
      push_a($sformatf("add_ph%0d_%0d", i % 8, i), 3'(i % 8), 1'b0, 1'b0);
      #2;
      e = sb.pop_front();
      n_checks++;
      if (obs_a !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %b want %b", e.name, obs_a, e.v);
      end
      if (i < 13) tick();
    end
    // Now mid phase 5: asynchronous reset must take effect without a clock edge.
    rst_a = 1'b0;
    #1;
    push_a("add_async_reset", 3'd0, 1'b0, 1'b0);
    e = sb.pop_front();
    n_checks++;
    if (obs_a !== e.v) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", e.name, obs_a, e.v);
    end
    tick();
    rst_a = 1'b1;
  endtask

  task automatic test_stall();
    exp_t e;
    int   ph_l[14];
    logic mr_l[14];
    ph_l = '{0, 1, 1, 2, 2, 3, 4, 5, 6, 6, 6, 6, 7, 7};
    mr_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
             1'b0, 1'b1};
    opcode_a = 4'd5;
    for (int i = 0; i < 14; i++) begin
      mem_ready_a = mr_l[i];
      push_a($sformatf("lda_stall_%0d", i), 3'(ph_l[i]), 1'b0, 1'b0);
      #2;
      e = sb.pop_front();
      n_checks++;
      if (obs_a !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %b want %b", e.name, obs_a, e.v);
      end
      tick();
    end
    mem_ready_a = 1'b1;
  endtask

  task automatic test_halt(input logic [3:0] hopc, input string tag);
    exp_t e;
    int   ph_l[16];
    logic hl_l[16];
    logic run_l[16];
    logic il;
    il    = (hopc > 4'd7);
    ph_l  = '{0, 1, 2, 3, 4, 0, 0, 0, 0, 1, 2, 3, 4, 5, 6, 7};
    hl_l  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b0};
    run_l = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 16; i++) begin
      opcode_a = (i < 8) ? hopc : 4'd3;
      run      = run_l[i];
      zero     = (i == 6);
      push_a($sformatf("%s_%0d", tag, i), 3'(ph_l[i]), hl_l[i], hl_l[i] && il);
      #2;
      e = sb.pop_front();
      n_checks++;
      if (obs_a !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %b want %b", e.name, obs_a, e.v);
      end
      tick();
    end
    run  = 1'b0;
    zero = 1'b0;
  endtask

  task automatic test_branch();
    exp_t e;
    logic [3:0] opc_l[5];
    logic       z_l[5];
    opc_l = '{4'd1, 4'd1, 4'd7, 4'd6, 4'd7};
    z_l   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int c = 0; c < 5; c++) begin
      for (int p = 0; p < 8; p++) begin
        opcode_a    = opc_l[c];
        zero        = z_l[c];
        mem_ready_a = (p >= 1 && p <= 3);
        push_a($sformatf("br_op%0d_z%0d_ph%0d", opc_l[c], z_l[c], p), 3'(p), 1'b0, 1'b0);
        #2;
        e = sb.pop_front();
        n_checks++;
        if (obs_a !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %b want %b", e.name, obs_a, e.v);
        end
        tick();
      end
    end
    zero        = 1'b0;
    mem_ready_a = 1'b1;
    opcode_a    = 4'd2;
  endtask

  task automatic test_no_wait();
    exp_t       e;
    logic [2:0] opc_l[8];
    opc_l       = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd0};
    mem_ready_b = 1'b0;
    zero        = 1'b1;
    tick();
    rst_b = 1'b1;
    for (int c = 0; c < 8; c++) begin
      for (int p = 0; p < 8; p++) begin
        opcode_b = opc_l[c];
        if (c == 7 && p == 5) begin
          push_b("nw_halted", 3'd0, 1'b1, 1'b0);
        end else begin
          push_b($sformatf("nw_op%0d_ph%0d", opc_l[c], p), 3'(p), 1'b0, 1'b0);
        end
        #2;
        e = sb.pop_front();
        n_checks++;
        if (obs_b !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %b want %b", e.name, obs_b, e.v);
        end
        tick();
        if (c == 7 && p == 5) break;
      end
    end
    zero = 1'b0;
  endtask

  initial begin
    rst_a       = 1'b1;
    rst_b       = 1'b1;
    opcode_a    = 4'd2;
    opcode_b    = 3'd2;
    zero        = 1'b0;
    run         = 1'b0;
    mem_ready_a = 1'b1;
    mem_ready_b = 1'b0;
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    test_reset();
    test_decode_add();
    test_stall();
    test_halt(4'd0, "hlt");
    test_halt(4'd9, "ill");
    test_branch();
    test_no_wait();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
